// File: rtl/dual_fetch_unit_if.sv
// Bundle of the fetch unit's memory, redirect and downstream signals.
//
// Handshake: a pair transfers on every rising clk edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready. While
// out_valid is 1 and out_ready is 0, the head pair holds steady. A redirect
// or reset discards the head pair without a transfer.
interface dual_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata_1;
    logic [31:0]       imem_rdata_2;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       instruction_1;
    logic [31:0]       instruction_2;
    logic [ADDR_W-1:0] out_pc;
    logic              instr2_valid;
    logic              done;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr,
        input  imem_rdata_1, imem_rdata_2,
        input  redirect_valid, redirect_pc,
        output out_valid,
        input  out_ready,
        output instruction_1, instruction_2, out_pc, instr2_valid, done
    );

    // Memory / consumer side
    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata_1, imem_rdata_2,
        output redirect_valid, redirect_pc,
        input  out_valid,
        output out_ready,
        input  instruction_1, instruction_2, out_pc, instr2_valid, done
    );
endinterface

// File: rtl/dual_fetch_unit.sv
// Dual-instruction fetch stage: issues pair reads to a 1-cycle dual-read
// instruction memory, buffers returned pairs in a small FIFO and presents
// the head pair downstream. A redirect flushes buffered and in-flight pairs.
module dual_fetch_unit #(
    parameter int ADDR_W     = 8,
    parameter int PC_MAX     = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    dual_fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // PC_MAX may equal 2^ADDR_W, so limit compares use one extra bit.
    localparam logic [ADDR_W:0] PC_LIMIT = (ADDR_W+1)'(PC_MAX);
    localparam logic [CNT_W:0]  DEPTH_W  = (CNT_W+1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              done_q;

    logic [31:0]       buf_i1 [FIFO_DEPTH];
    logic [31:0]       buf_i2 [FIFO_DEPTH];
    logic [ADDR_W-1:0] buf_pc [FIFO_DEPTH];
    logic              buf_v2 [FIFO_DEPTH];

    logic              empty;
    logic              pc_in_range;
    logic [CNT_W:0]    credits_used;
    logic              issue;
    logic              push;
    logic              pop;
    logic              resp_v2;

    assign empty        = (count == '0);
    assign pc_in_range  = ({1'b0, fetch_pc} < PC_LIMIT);
    // Buffered plus in-flight pairs; a request needs a guaranteed free slot.
    assign credits_used = {1'b0, count} + (CNT_W+1)'(inflight);
    assign issue        = !reset && !bus.redirect_valid && pc_in_range
                          && (credits_used < DEPTH_W);
    assign push         = inflight && !bus.redirect_valid;
    assign pop          = !empty && bus.out_ready && !bus.redirect_valid;
    assign resp_v2      = (({1'b0, req_pc} + (ADDR_W+1)'(1)) < PC_LIMIT);

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = !empty;
    assign bus.done      = done_q;

    // Fetch PC, request tracking, FIFO pointers/occupancy and done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= '0;
            req_pc   <= '0;
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            done_q   <= 1'b0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc;
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            done_q   <= 1'b0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(2);
                req_pc   <= fetch_pc;
            end
            inflight <= issue;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            done_q <= !pc_in_range && empty && !inflight;
        end
    end

    // Pair storage; a second instruction past the program end is stored as 0.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_i1[wr_ptr] <= bus.imem_rdata_1;
            buf_i2[wr_ptr] <= resp_v2 ? bus.imem_rdata_2 : 32'h0;
            buf_pc[wr_ptr] <= req_pc;
            buf_v2[wr_ptr] <= resp_v2;
        end
    end

    // Head pair to the outputs, forced to zero while the FIFO is empty.
    always_comb begin
        bus.instruction_1 = 32'h0;
        bus.instruction_2 = 32'h0;
        bus.out_pc        = '0;
        bus.instr2_valid  = 1'b0;
        if (!empty) begin
            bus.instruction_1 = buf_i1[rd_ptr];
            bus.instruction_2 = buf_i2[rd_ptr];
            bus.out_pc        = buf_pc[rd_ptr];
            bus.instr2_valid  = buf_v2[rd_ptr];
        end
    end
endmodule

// File: tb/tb_dual_fetch_unit.sv
// Bench for dual_fetch_unit: instance a uses PC_MAX=20, instance b PC_MAX=5.
// Memory model returns mem[i] = 0x1000 + i one cycle after each request.
module tb_dual_fetch_unit;
    localparam int W = 8 + 32 + 32 + 1;

    logic clk = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_q_b[$];

    dual_fetch_unit_if #(.ADDR_W(8)) bus_a ();
    dual_fetch_unit_if #(.ADDR_W(8)) bus_b ();

    dual_fetch_unit #(.ADDR_W(8), .PC_MAX(20), .FIFO_DEPTH(4)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a.master)
    );

    dual_fetch_unit #(.ADDR_W(8), .PC_MAX(5), .FIFO_DEPTH(4)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b.master)
    );

    // clock / reset
    always #5 clk = ~clk;

    // dual-read memory models, 1-cycle latency
    always @(posedge clk) begin
        bus_a.imem_rdata_1 <= 32'h1000 + 32'(bus_a.imem_addr);
        bus_a.imem_rdata_2 <= 32'h1001 + 32'(bus_a.imem_addr);
        bus_b.imem_rdata_1 <= 32'h1000 + 32'(bus_b.imem_addr);
        bus_b.imem_rdata_2 <= 32'h1001 + 32'(bus_b.imem_addr);
    end

    function automatic logic [W-1:0] exp_pair(input logic [7:0] pc, input int pc_max);
        logic v2;
        v2 = (int'(pc) + 1) < pc_max;
        return {pc, 32'h1000 + 32'(pc), (v2 ? 32'h1001 + 32'(pc) : 32'h0), v2};
    endfunction

    // one clock: scoreboard pop/compare for instance a, then land at posedge+1
    task automatic tick();
        logic [W-1:0] obs;
        logic [W-1:0] exp;
        @(negedge clk);
        if (!reset_a && !bus_a.redirect_valid && bus_a.out_valid && bus_a.out_ready) begin
            obs = {bus_a.out_pc, bus_a.instruction_1, bus_a.instruction_2, bus_a.instr2_valid};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got pair %h, required none", obs);
            end else begin
                exp = exp_q.pop_front();
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL sb_pair: got %h, required %h", obs, exp);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input int limit, input string name);
        int n;
        n = 0;
        while (!bus_a.done && n < limit) begin
            tick();
            n++;
        end
        vectors++;
        if (bus_a.done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, bus_a.done, n);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_leftover: %0d pairs not delivered, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        bus_a.out_ready = 1'b1;
        bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc = '0;
        bus_b.out_ready = 1'b1;
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc = '0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus_a.imem_req, bus_a.out_valid, bus_a.done, bus_a.instr2_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: req/valid/done/v2=%b, required 0000",
                     {bus_a.imem_req, bus_a.out_valid, bus_a.done, bus_a.instr2_valid});
        end
        vectors++;
        if ({bus_a.instruction_1, bus_a.instruction_2, bus_a.out_pc} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: i1=%h i2=%h pc=%h, required 0",
                     bus_a.instruction_1, bus_a.instruction_2, bus_a.out_pc);
        end
    endtask

    task automatic test_stream();
        exp_q.delete();
        for (int p = 0; p < 20; p += 2) exp_q.push_back(exp_pair(8'(p), 20));
        bus_a.out_ready = 1'b1;
        reset_a = 1'b0;
        #1;
        tick();
        vectors++;
        if (bus_a.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_latency1: out_valid=%b, required 0", bus_a.out_valid);
        end
        tick();
        vectors++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_pc !== 8'd0) begin
            miscompares++;
            $display("FAIL stream_latency2: out_valid=%b pc=%0d, required 1 pc 0", bus_a.out_valid, bus_a.out_pc);
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (bus_a.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_gap: cycle %0d out_valid=%b, required 1", i, bus_a.out_valid);
            end
            tick();
        end
        vectors++;
        if (bus_a.done !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_done_early: done=%b, required 0", bus_a.done);
        end
        wait_done_a(4, "stream");
    endtask

    task automatic test_back_to_back();
        int reqs;
        reset_a = 1'b1;
        tick();
        exp_q.delete();
        for (int p = 0; p < 20; p += 2) exp_q.push_back(exp_pair(8'(p), 20));
        bus_a.out_ready = 1'b0;
        reset_a = 1'b0;
        #1;
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_a.imem_req) reqs++;
            tick();
        end
        vectors++;
        if (reqs != 4 || bus_a.imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_credit: %0d requests req=%b, required 4 and 0", reqs, bus_a.imem_req);
        end
        vectors++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_pc !== 8'd0) begin
            miscompares++;
            $display("FAIL stall_head: valid=%b pc=%0d, required 1 pc 0", bus_a.out_valid, bus_a.out_pc);
        end
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (bus_a.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL full_throughput: cycle %0d out_valid=%b, required 1", i, bus_a.out_valid);
            end
            tick();
        end
        wait_done_a(6, "stall");
    endtask

    task automatic test_redirect();
        int n;
        reset_a = 1'b1;
        tick();
        exp_q.delete();
        bus_a.out_ready = 1'b0;
        reset_a = 1'b0;
        #1;
        tick();
        tick();
        tick();
        vectors++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_pc !== 8'd0) begin
            miscompares++;
            $display("FAIL redir_setup: valid=%b pc=%0d, required 1 pc 0", bus_a.out_valid, bus_a.out_pc);
        end
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc = 8'd8;
        for (int p = 8; p < 20; p += 2) exp_q.push_back(exp_pair(8'(p), 20));
        #1;
        vectors++;
        if (bus_a.imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_noreq: imem_req=%b, required 0", bus_a.imem_req);
        end
        tick();
        bus_a.redirect_valid = 1'b0;
        bus_a.out_ready = 1'b1;
        vectors++;
        if (bus_a.out_valid !== 1'b0 || bus_a.done !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_flush: valid=%b done=%b, required 0 0", bus_a.out_valid, bus_a.done);
        end
        n = 0;
        while (!bus_a.out_valid && n < 4) begin
            tick();
            n++;
        end
        vectors++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_pc !== 8'd8 || n > 2) begin
            miscompares++;
            $display("FAIL redir_restart: valid=%b pc=%0d after %0d cycles, required 1 pc 8 within 2",
                     bus_a.out_valid, bus_a.out_pc, n);
        end
        wait_done_a(30, "redir");
    endtask

    task automatic test_reset_midstream();
        reset_a = 1'b1;
        tick();
        exp_q.delete();
        bus_a.out_ready = 1'b0;
        reset_a = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (bus_a.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_setup: out_valid=%b, required 1", bus_a.out_valid);
        end
        reset_a = 1'b1;
        tick();
        vectors++;
        if ({bus_a.out_valid, bus_a.done, bus_a.imem_req} !== 3'b000 || bus_a.out_pc !== 8'd0) begin
            miscompares++;
            $display("FAIL midrst_clear: valid/done/req=%b pc=%0d, required 000 pc 0",
                     {bus_a.out_valid, bus_a.done, bus_a.imem_req}, bus_a.out_pc);
        end
        for (int p = 0; p < 20; p += 2) exp_q.push_back(exp_pair(8'(p), 20));
        reset_a = 1'b0;
        bus_a.out_ready = 1'b1;
        #1;
        wait_done_a(30, "midrst");
    endtask

    task automatic test_pc_max_small();
        logic [W-1:0] obs;
        logic [W-1:0] exp;
        exp_q_b.delete();
        for (int p = 0; p < 5; p += 2) exp_q_b.push_back(exp_pair(8'(p), 5));
        bus_b.out_ready = 1'b1;
        reset_b = 1'b0;
        #1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus_b.imem_req) begin
                vectors++;
                if (bus_b.imem_addr >= 8'd5) begin
                    miscompares++;
                    $display("FAIL small_req_range: addr=%0d, required < 5", bus_b.imem_addr);
                end
            end
            if (bus_b.out_valid && bus_b.out_ready) begin
                obs = {bus_b.out_pc, bus_b.instruction_1, bus_b.instruction_2, bus_b.instr2_valid};
                vectors++;
                if (exp_q_b.size() == 0) begin
                    miscompares++;
                    $display("FAIL small_unexpected: got pair %h, required none", obs);
                end else begin
                    exp = exp_q_b.pop_front();
                    if (obs !== exp) begin
                        miscompares++;
                        $display("FAIL small_pair: got %h, required %h", obs, exp);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (exp_q_b.size() != 0 || bus_b.done !== 1'b1) begin
            miscompares++;
            $display("FAIL small_end: %0d left, done=%b, required 0 left done 1", exp_q_b.size(), bus_b.done);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_redirect();
        test_reset_midstream();
        test_pc_max_small();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
